logic_unit_mc: RTL and testbench

- Parametrised multi-cycle bitwise logic unit; successor to the fixed 32-bit XOR array.
- Computes AND/OR/XOR/NOR of two WIDTH-bit operands, CHUNK bits per cycle.
- Uses a start/busy/done handshake.
- Sits beside the ALU for the multi-cycle datapath variant; also serves as a width-agnostic logic primitive.

---
 rtl/logic_unit_mc.sv | 162 ++++++++++++++++
 tb/tb_logic_unit_mc.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_mc.sv
// logic_unit_mc: multi-cycle AND/OR/XOR/NOR of two WIDTH-bit operands, CHUNK bits/cycle.
// Optional registered zero flag Z when LOGIC_UNIT_MC_ZFLAG_EN is defined.
`timescale 1ns/1ps
module logic_unit_mc #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] O,
  output logic             busy,
  output logic             done
`ifdef LOGIC_UNIT_MC_ZFLAG_EN
  ,
  output logic             Z
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("logic_unit_mc: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  function automatic logic [CHUNK-1:0] lop(
    input logic [1:0]       o,
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b
  );
    logic [CHUNK-1:0] r;
    unique case (o)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~(a | b);
    endcase
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CHUNK-1:0] chunk;
  logic             last;
`ifdef LOGIC_UNIT_MC_ZFLAG_EN
  logic             zacc_q, zacc_d;
  logic             z_q, z_d;
`endif

  assign last = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    o_d     = o_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    chunk   = '0;
`ifdef LOGIC_UNIT_MC_ZFLAG_EN
    zacc_d  = zacc_q;
    z_d     = z_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          op_d    = op;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        for (int i = 0; i < N; i++) begin
          if (cnt_q == CW'(i)) begin
            chunk = lop(op_q,
                        a_q[i*CHUNK +: CHUNK],
                        b_q[i*CHUNK +: CHUNK]);
            res_d[i*CHUNK +: CHUNK] = chunk;
          end
        end
`ifdef LOGIC_UNIT_MC_ZFLAG_EN
        // first chunk restarts the running all-zero flag
        zacc_d = ((cnt_q == '0) ? 1'b1 : zacc_q) & ~(|chunk);
`endif
        if (last) begin
          o_d     = res_d;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
`ifdef LOGIC_UNIT_MC_ZFLAG_EN
          z_d     = zacc_d;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      o_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LOGIC_UNIT_MC_ZFLAG_EN
      zacc_q  <= 1'b0;
      z_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LOGIC_UNIT_MC_ZFLAG_EN
      zacc_q  <= zacc_d;
      z_q     <= z_d;
`endif
    end
  end

  assign O    = o_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef LOGIC_UNIT_MC_ZFLAG_EN
  assign Z    = z_q;
`endif

endmodule

// File: tb/tb_logic_unit_mc.sv
// Directed self-checking bench for logic_unit_mc (three configurations).
// Zero-flag checks are compiled in with LOGIC_UNIT_MC_ZFLAG_EN.
`timescale 1ns/1ps
module tb_logic_unit_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
  logic [1:0]  op0 = 2'b00, op1 = 2'b00;
  logic [31:0] a0 = '0, b0 = '0;
  logic [63:0] a1 = '0, b1 = '0;
  logic [31:0] o0, o2;
  logic [63:0] o1;
  logic        busy0, done0, busy1, done1, busy2, done2;
`ifdef LOGIC_UNIT_MC_ZFLAG_EN
  logic        z0, z1, z2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic_unit_mc #(.WIDTH(32), .CHUNK(8)) d0 (
    .clk(clk), .rst_n(rst_n), .start(s0), .op(op0),
    .A(a0), .B(b0), .O(o0), .busy(busy0), .done(done0)
`ifdef LOGIC_UNIT_MC_ZFLAG_EN
    , .Z(z0)
`endif
  );

  logic_unit_mc #(.WIDTH(64), .CHUNK(16)) d1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .op(op1),
    .A(a1), .B(b1), .O(o1), .busy(busy1), .done(done1)
`ifdef LOGIC_UNIT_MC_ZFLAG_EN
    , .Z(z1)
`endif
  );

  logic_unit_mc #(.WIDTH(32), .CHUNK(32)) d2 (
    .clk(clk), .rst_n(rst_n), .start(s2), .op(op0),
    .A(a0), .B(b0), .O(o2), .busy(busy2), .done(done2)
`ifdef LOGIC_UNIT_MC_ZFLAG_EN
    , .Z(z2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int dn;
    rst_n = 1'b0;
    s0 = 1'b1;
    a0 = $urandom;
    b0 = $urandom;
    op0 = 2'b10;
    repeat (3) tick();
    checks++;
    if (o0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_O: got %h want %h", o0, 32'h0);
    end
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b want 0 0", busy0, done0);
    end
    checks++;
    if (o1 !== 64'h0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_cfg: O1=%h busy2=%b want 0 0", o1, busy2);
    end
`ifdef LOGIC_UNIT_MC_ZFLAG_EN
    checks++;
    if (z0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_Z: got %b want 0", z0);
    end
`endif
    s0 = 1'b0;
    #2 rst_n = 1'b1;
    dn = 0;
    repeat (6) begin
      tick();
      if (done0) dn++;
    end
    checks++;
    if (dn !== 0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: dones=%0d busy=%b want 0 0", dn, busy0);
    end
  endtask

  task automatic test_xor();
    a0 = 32'hFFFF0000;
    b0 = 32'h0F0F0F0F;
    op0 = 2'b10;
    s0 = 1'b1;
    tick();
    s0 = 1'b0;
    for (int e = 0; e < 3; e++) begin
      checks++;
      if (busy0 !== 1'b1 || done0 !== 1'b0 || o0 !== 32'h0) begin
        errors++;
        $display("FAIL xor_run%0d: busy=%b done=%b O=%h want 1 0 0",
                 e, busy0, done0, o0);
      end
      tick();
    end
    checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL xor_edge3: busy=%b done=%b want 1 0", busy0, done0);
    end
    tick();
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || o0 !== 32'hF0F00F0F) begin
      errors++;
      $display("FAIL xor_done: done=%b busy=%b O=%h want 1 0 f0f00f0f",
               done0, busy0, o0);
    end
    tick();
    checks++;
    if (done0 !== 1'b0 || o0 !== 32'hF0F00F0F) begin
      errors++;
      $display("FAIL xor_pulse: done=%b O=%h want 0 f0f00f0f", done0, o0);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [3];
    logic [31:0] exp [3];
    logic [31:0] prev;
    int c;
    ops = '{2'b00, 2'b01, 2'b11};
    exp = '{32'h0F0F0000, 32'hFFFF0F0F, 32'h0000F0F0};
    prev = 32'hF0F00F0F;
    for (int k = 0; k < 3; k++) begin
      op0 = ops[k];
      s0 = 1'b1;
      tick();
      s0 = 1'b0;
      checks++;
      if (busy0 !== 1'b1 || done0 !== 1'b0 || o0 !== prev) begin
        errors++;
        $display("FAIL b2b_accept%0d: busy=%b done=%b O=%h want 1 0 %h",
                 k, busy0, done0, o0, prev);
      end
      c = 0;
      while (c < 10) begin
        tick();
        c++;
        if (done0) break;
      end
      checks++;
      if (c !== 4 || o0 !== exp[k]) begin
        errors++;
        $display("FAIL b2b_result%0d: edges=%0d O=%h want 4 %h",
                 k, c, o0, exp[k]);
      end
      prev = exp[k];
    end
  endtask

  task automatic test_reset_mid();
    int dn;
    int c;
    a0 = 32'hFFFF0000;
    b0 = 32'h0F0F0F0F;
    op0 = 2'b10;
    s0 = 1'b1;
    tick();
    s0 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (o0 !== 32'h0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL midrst: O=%h busy=%b done=%b want 0 0 0",
               o0, busy0, done0);
    end
    #1 rst_n = 1'b1;
    dn = 0;
    repeat (6) begin
      tick();
      if (done0) dn++;
    end
    checks++;
    if (dn !== 0 || o0 !== 32'h0) begin
      errors++;
      $display("FAIL midrst_abort: dones=%0d O=%h want 0 0", dn, o0);
    end
    a0 = 32'hAAAAAAAA;
    b0 = 32'h55555555;
    op0 = 2'b10;
    s0 = 1'b1;
    tick();
    s0 = 1'b0;
    c = 0;
    while (c < 10) begin
      tick();
      c++;
      if (done0) break;
    end
    checks++;
    if (c !== 4 || o0 !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL midrst_clean: edges=%0d O=%h want 4 ffffffff", c, o0);
    end
    tick();
  endtask

  task automatic test_churn();
    int dn;
    int at;
    a0 = 32'h12345678;
    b0 = 32'h0;
    op0 = 2'b00;
    s0 = 1'b1;
    tick();
    dn = 0;
    at = 0;
    for (int i = 1; i <= 8; i++) begin
      a0 = $urandom;
      b0 = $urandom;
      op0 = 2'($urandom_range(3));
      s0 = (i == 2);
      tick();
      if (done0) begin
        dn++;
        at = i;
        checks++;
        if (o0 !== 32'h0) begin
          errors++;
          $display("FAIL churn_O: got %h want 00000000", o0);
        end
      end
    end
    s0 = 1'b0;
    checks++;
    if (dn !== 1 || at !== 4) begin
      errors++;
      $display("FAIL churn_done: dones=%0d at=%0d want 1 4", dn, at);
    end
  endtask

  task automatic test_config();
    int c;
    a1 = '0;
    b1 = '0;
    op1 = 2'b11;
    s1 = 1'b1;
    tick();
    s1 = 1'b0;
    c = 0;
    while (c < 10) begin
      tick();
      c++;
      if (done1) break;
    end
    checks++;
    if (c !== 4 || o1 !== {64{1'b1}} || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL cfg64: edges=%0d O=%h busy=%b want 4 ffffffffffffffff 0",
               c, o1, busy1);
    end
    a0 = 32'h12345678;
    b0 = 32'hFFFF0000;
    op0 = 2'b10;
    s2 = 1'b1;
    tick();
    s2 = 1'b0;
    checks++;
    if (busy2 !== 1'b1 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL cfg32_busy: busy=%b done=%b want 1 0", busy2, done2);
    end
    c = 0;
    while (c < 10) begin
      tick();
      c++;
      if (done2) break;
    end
    checks++;
    if (c !== 1 || o2 !== 32'hEDCB5678) begin
      errors++;
      $display("FAIL cfg32: edges=%0d O=%h want 1 edcb5678", c, o2);
    end
    tick();
  endtask

`ifdef LOGIC_UNIT_MC_ZFLAG_EN
  task automatic test_zflag();
    int c;
    a0 = 32'hDEADBEEF;
    b0 = 32'hDEADBEEF;
    op0 = 2'b10;
    s0 = 1'b1;
    tick();
    s0 = 1'b0;
    c = 0;
    while (c < 10) begin
      tick();
      c++;
      if (done0) break;
    end
    checks++;
    if (z0 !== 1'b1 || o0 !== 32'h0) begin
      errors++;
      $display("FAIL zflag_one: Z=%b O=%h want 1 0", z0, o0);
    end
    a0 = 32'h01000000;
    b0 = 32'h0;
    s0 = 1'b1;
    tick();
    s0 = 1'b0;
    c = 0;
    while (c < 10) begin
      tick();
      c++;
      if (done0) break;
    end
    checks++;
    if (z0 !== 1'b0 || o0 !== 32'h01000000) begin
      errors++;
      $display("FAIL zflag_zero: Z=%b O=%h want 0 01000000", z0, o0);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_xor();
    test_back_to_back();
    test_reset_mid();
    test_churn();
    test_config();
`ifdef LOGIC_UNIT_MC_ZFLAG_EN
    test_zflag();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
